// File: rtl/psk_pkg.sv
// rtl/psk_pkg.sv - shared constants, bit-field positions and mode encoding for the PSK modem
package psk_pkg;
   localparam int SPS   = 16;
   localparam int BIT_I = 1;
   localparam int BIT_Q = 0;

   typedef enum logic {MODE_QPSK = 1'b0, MODE_BPSK = 1'b1} psk_mode_e;

   function automatic int acc_width(input int w);
      return 2 * w + 4;
   endfunction
endpackage

// File: rtl/psk_corr_acc.sv
// rtl/psk_corr_acc.sv - one mixer lane: registered product feeding an integrate-and-dump accumulator
module psk_corr_acc
   import psk_pkg::*;
#(
   parameter int WIDTH = 12,
   localparam int AW = acc_width(WIDTH)
)
(
   input  logic                    clk_16M384,
   input  logic                    rst_16M384,
   input  logic signed [WIDTH-1:0] sample,
   input  logic signed [WIDTH-1:0] carrier,
   input  logic                    acc_en,
   input  logic                    acc_load,
   output logic signed [AW-1:0]    acc
);
   logic signed [2*WIDTH-1:0] prod;
   logic signed [AW-1:0]      prod_ext;

   assign prod_ext = {{(AW - 2*WIDTH){prod[2*WIDTH-1]}}, prod};

   always_ff @(posedge clk_16M384) begin
      if (rst_16M384) begin
         prod <= '0;
         acc  <= '0;
      end else begin
         prod <= sample * carrier;
         if (acc_en) begin
            acc <= acc_load ? prod_ext : acc + prod_ext;
         end
      end
   end
endmodule

// File: rtl/psk_demod.sv
// rtl/psk_demod.sv - coherent BPSK/QPSK demodulator with AXIS symbol output
module psk_demod
   import psk_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int BYTES = 1
)
(
   input  logic                    clk_16M384,
   input  logic                    rst_16M384,
   input  logic signed [WIDTH-1:0] rx,
   input  logic signed [WIDTH-1:0] carrier_I,
   input  logic signed [WIDTH-1:0] carrier_Q,
   input  logic                    demod_en,
   input  logic                    is_bpsk,
   input  logic [3:0]              SYM_PHASE,
   input  logic [15:0]             FRAME_LEN,
   output logic [BYTES*8-1:0]      m_tdata,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
   output logic                    m_tuser,
   output logic                    sym_strobe,
   output logic                    overflow
);
   localparam int AW = acc_width(WIDTH);
   localparam logic [3:0] LAST_OFS = 4'(SPS - 1);

   logic [3:0]           cnt;
   logic                 win_active;
   psk_mode_e            win_mode, s1_mode, s2_mode;
   logic                 s1_valid, s1_first, s1_last, s2_dump;
   logic [15:0]          frame_cnt;
   logic signed [AW-1:0] acc_i, acc_q;
   logic [AW:0]          acc_sum;
   logic                 win_start, win_end, bit_i, bit_q, end_of_frame;

   assign win_start    = demod_en && (cnt == SYM_PHASE);
   assign win_end      = demod_en && win_active && (cnt == SYM_PHASE + LAST_OFS);
   assign end_of_frame = (FRAME_LEN != 16'd0) && (frame_cnt == FRAME_LEN - 16'd1);

   psk_corr_acc #(.WIDTH(WIDTH)) u_lane_i (
      .clk_16M384 (clk_16M384),
      .rst_16M384 (rst_16M384),
      .sample     (rx),
      .carrier    (carrier_I),
      .acc_en     (s1_valid),
      .acc_load   (s1_first),
      .acc        (acc_i)
   );

   psk_corr_acc #(.WIDTH(WIDTH)) u_lane_q (
      .clk_16M384 (clk_16M384),
      .rst_16M384 (rst_16M384),
      .sample     (rx),
      .carrier    (carrier_Q),
      .acc_en     (s1_valid),
      .acc_load   (s1_first),
      .acc        (acc_q)
   );

   // BPSK sums both lanes one bit wider so the sign is exact
   always_comb begin
      acc_sum = {acc_i[AW-1], acc_i} + {acc_q[AW-1], acc_q};
      bit_i   = !acc_i[AW-1];
      bit_q   = !acc_q[AW-1];
      if (s2_mode == MODE_BPSK) begin
         bit_i = !acc_sum[AW];
         bit_q = !acc_sum[AW];
      end
   end

   always_ff @(posedge clk_16M384) begin
      if (rst_16M384) begin
         cnt        <= '0;
         win_active <= 1'b0;
         win_mode   <= MODE_QPSK;
         s1_valid   <= 1'b0;
         s1_first   <= 1'b0;
         s1_last    <= 1'b0;
         s1_mode    <= MODE_QPSK;
         s2_dump    <= 1'b0;
         s2_mode    <= MODE_QPSK;
         frame_cnt  <= '0;
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         m_tuser    <= 1'b0;
         sym_strobe <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (!demod_en) begin
            cnt        <= '0;
            win_active <= 1'b0;
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s2_dump    <= 1'b0;
            frame_cnt  <= '0;
         end else begin
            cnt      <= cnt + 4'd1;
            if (win_start) begin
               win_active <= 1'b1;
               win_mode   <= psk_mode_e'(is_bpsk);
            end
            s1_valid <= win_active || win_start;
            s1_first <= win_start;
            s1_last  <= win_end;
            s1_mode  <= win_mode;
            s2_dump  <= s1_valid && s1_last;
            s2_mode  <= s1_mode;
         end

         sym_strobe <= demod_en && s2_dump;
         if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
         end

         // single-entry output: a dump while a symbol is still held is dropped
         if (demod_en && s2_dump) begin
            if (!m_tvalid || m_tready) begin
               m_tdata        <= '0;
               m_tdata[BIT_I] <= bit_i;
               m_tdata[BIT_Q] <= bit_q;
               m_tvalid       <= 1'b1;
               m_tuser        <= (s2_mode == MODE_BPSK);
               m_tlast        <= end_of_frame;
               frame_cnt      <= end_of_frame ? 16'd0 : frame_cnt + 16'd1;
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_psk_demod.sv
// tb/tb_psk_demod.sv - directed bench with a window-level behavioural model of psk_demod
module tb_psk_demod;
   logic               clk_16M384 = 1'b0;
   logic               rst_16M384;
   logic signed [11:0] rx, carrier_I, carrier_Q;
   logic               demod_en, is_bpsk, m_tready;
   logic [3:0]         SYM_PHASE;
   logic [15:0]        FRAME_LEN;
   logic [7:0]         m_tdata;
   logic               m_tvalid, m_tlast, m_tuser, sym_strobe, overflow;

   psk_demod #(.WIDTH(12), .BYTES(1)) dut (
      .clk_16M384 (clk_16M384),
      .rst_16M384 (rst_16M384),
      .rx         (rx),
      .carrier_I  (carrier_I),
      .carrier_Q  (carrier_Q),
      .demod_en   (demod_en),
      .is_bpsk    (is_bpsk),
      .SYM_PHASE  (SYM_PHASE),
      .FRAME_LEN  (FRAME_LEN),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .m_tuser    (m_tuser),
      .sym_strobe (sym_strobe),
      .overflow   (overflow)
   );

   always #5 clk_16M384 = ~clk_16M384;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int cos_tab[16] = '{2047, 1891, 1447, 783, 0, -783, -1447, -1891,
                       -2047, -1891, -1447, -783, 0, 783, 1447, 1891};

   typedef struct { longint due; logic [1:0] data; logic user; } sym_t;
   typedef struct { logic [7:0] data; logic last; logic user; } xfer_t;

   sym_t   pend[$];
   xfer_t  dut_log[$];
   longint cyc = 0;
   longint fv_cyc = -1;
   bit     chk_on = 0;

   int     en_cnt, n_in, frame_n;
   bit     in_win, wmode;
   longint sum_i, sum_q;
   bit     e_valid, e_strobe, e_ovf, e_last, e_user;
   logic [1:0] e_data;

   // Model: integrate whole windows, emit the decision two edges later,
   // then apply the single-entry hold/drop and frame rules.
   always @(posedge clk_16M384) begin
      sym_t s;
      bit bi, bq;
      cyc = cyc + 1;
      if (rst_16M384) begin
         chk_on = 1; en_cnt = 0; in_win = 0; frame_n = 0; pend.delete();
         e_valid = 0; e_strobe = 0; e_ovf = 0; e_last = 0; e_user = 0; e_data = 0;
      end else begin
         e_strobe = 0;
         if (e_valid && m_tready) e_valid = 0;
         if (demod_en) begin
            if (en_cnt % 16 == int'(SYM_PHASE)) begin
               in_win = 1; n_in = 0; sum_i = 0; sum_q = 0; wmode = is_bpsk;
            end
            en_cnt++;
            if (in_win) begin
               sum_i += longint'(rx) * longint'(carrier_I);
               sum_q += longint'(rx) * longint'(carrier_Q);
               n_in++;
               if (n_in == 16) begin
                  bi = wmode ? (sum_i + sum_q >= 0) : (sum_i >= 0);
                  bq = wmode ? (sum_i + sum_q >= 0) : (sum_q >= 0);
                  s.due = cyc + 2; s.data = {bi, bq}; s.user = wmode;
                  pend.push_back(s);
                  in_win = 0;
               end
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
               s = pend.pop_front();
               e_strobe = 1;
               if (!e_valid) begin
                  e_valid = 1; e_data = s.data; e_user = s.user; e_last = 0;
                  if (FRAME_LEN != 0) e_last = (frame_n % FRAME_LEN) == FRAME_LEN - 1;
                  frame_n++;
               end else begin
                  e_ovf = 1;
               end
            end
         end else begin
            en_cnt = 0; in_win = 0; frame_n = 0; pend.delete();
         end
      end
   end

   always @(negedge clk_16M384) begin
      if (chk_on) begin
         chk("m_tvalid", m_tvalid, e_valid);
         chk("sym_strobe", sym_strobe, e_strobe);
         chk("overflow", overflow, e_ovf);
         if (e_valid) begin
            chk("m_tdata", m_tdata, longint'(e_data));
            chk("m_tlast", m_tlast, e_last);
            chk("m_tuser", m_tuser, e_user);
         end
         if (m_tvalid && fv_cyc < 0) fv_cyc = cyc;
         if (m_tvalid && m_tready) dut_log.push_back('{m_tdata, m_tlast, m_tuser});
      end
   end

   int si = 0, sq = 0, ph = 0;
   bit rnd_rx = 0;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         carrier_I = 12'(cos_tab[ph]);
         carrier_Q = 12'(cos_tab[(ph + 12) % 16]);
         rx = rnd_rx ? 12'($urandom_range(0, 4095))
                     : 12'((si * cos_tab[ph] + sq * cos_tab[(ph + 12) % 16]) / 2);
         ph = (ph + 1) % 16;
         @(posedge clk_16M384);
         #1;
      end
   endtask

   task automatic send(input int a_i, input int a_q, input int n);
      si = a_i; sq = a_q;
      step(n);
   endtask

   task automatic start_run();
      dut_log.delete();
      fv_cyc = -1;
      demod_en = 1;
   endtask

   task automatic stop_run();
      demod_en = 0;
      send(0, 0, 4);
   endtask

   longint k;

   initial begin
      rst_16M384 = 1; demod_en = 1; is_bpsk = 0; m_tready = 1;
      SYM_PHASE = 0; FRAME_LEN = 0; rnd_rx = 1;
      step(3);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tuser", m_tuser, 0);
      chk("rst_strobe", sym_strobe, 0);
      chk("rst_overflow", overflow, 0);

      rst_16M384 = 0;
      k = cyc; start_run();
      step(17);
      chk("rst_no_early_valid", fv_cyc, -1);
      step(2);
      chk("rst_first_valid_cycle", fv_cyc - k, 18);
      rnd_rx = 0;
      stop_run();

      // QPSK: (+,+) (-,+) (+,-) (-,-), trailing partial window is aborted
      k = cyc; start_run();
      send(1, 1, 16); send(-1, 1, 16); send(1, -1, 16); send(-1, -1, 16);
      send(0, 0, 4);
      stop_run();
      chk("qpsk_latency", fv_cyc - k, 18);
      chk("qpsk_count", dut_log.size(), 4);
      if (dut_log.size() == 4) begin
         chk("qpsk_sym0", dut_log[0].data, 3);
         chk("qpsk_sym1", dut_log[1].data, 1);
         chk("qpsk_sym2", dut_log[2].data, 2);
         chk("qpsk_sym3", dut_log[3].data, 0);
         chk("qpsk_user", dut_log[3].user, 0);
      end

      is_bpsk = 1;
      start_run();
      send(-1, -1, 16); send(1, 1, 16); send(0, 0, 4);
      stop_run();
      chk("bpsk_count", dut_log.size(), 2);
      if (dut_log.size() == 2) begin
         chk("bpsk_sym0", dut_log[0].data, 0);
         chk("bpsk_sym1", dut_log[1].data, 3);
         chk("bpsk_user", dut_log[1].user, 1);
      end

      is_bpsk = 0; FRAME_LEN = 4;
      start_run();
      for (int i = 0; i < 10; i++) send((i % 2) ? 1 : -1, (i % 3) ? 1 : -1, 16);
      send(0, 0, 4);
      stop_run();
      chk("frame4_count", dut_log.size(), 10);
      for (int i = 0; i < dut_log.size(); i++)
         chk($sformatf("frame4_tlast%0d", i), dut_log[i].last, (i == 3 || i == 7) ? 1 : 0);

      FRAME_LEN = 0;
      start_run();
      for (int i = 0; i < 5; i++) send(1, -1, 16);
      send(0, 0, 4);
      stop_run();
      chk("frame0_count", dut_log.size(), 5);
      for (int i = 0; i < dut_log.size(); i++)
         chk($sformatf("frame0_tlast%0d", i), dut_log[i].last, 0);

      // phase 5 with zero input: first window from cnt=5, tie decides 11
      SYM_PHASE = 5;
      k = cyc; start_run();
      send(0, 0, 24);
      stop_run();
      chk("phase5_first_valid", fv_cyc - k, 23);
      chk("phase5_count", dut_log.size(), 1);
      if (dut_log.size() == 1) chk("phase5_tie", dut_log[0].data, 3);
      SYM_PHASE = 0;

      m_tready = 0;
      start_run();
      send(1, 1, 16); send(-1, -1, 16); send(0, 0, 4);
      demod_en = 0;
      send(0, 0, 3);
      chk("bp_overflow", overflow, 1);
      chk("bp_held_valid", m_tvalid, 1);
      chk("bp_held_data", m_tdata, 3);
      chk("bp_no_xfer", dut_log.size(), 0);
      m_tready = 1;
      step(1);
      m_tready = 0;
      step(3);
      chk("bp_one_xfer", dut_log.size(), 1);
      if (dut_log.size() == 1) chk("bp_xfer_data", dut_log[0].data, 3);
      chk("bp_valid_cleared", m_tvalid, 0);
      chk("bp_overflow_sticky", overflow, 1);

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/psk_demod.md
# psk_demod

Coherent BPSK/QPSK demodulator: the receive-side counterpart of the PSK modulator. It correlates the received passband sample stream against locally supplied carrier I/Q references, integrates and dumps over each 16-sample symbol at 16.384 MHz (1.024 Msym/s), and makes hard bit decisions. Decided symbols leave on an AXI-Stream master carrying the same data layout, `tuser = is_bpsk` and `tlast` framing that the modulator consumes. The carrier references come from the upstream NCO/carrier-recovery block.

## Interface
- `WIDTH`, 12: sample and carrier width (signed).
- `BYTES`, 1: AXIS data width in bytes (≥1).
- `clk_16M384` in 1: single clock for the whole block.
- `rst_16M384` in 1: reset. Synchronous, active-high.
- `rx` in WIDTH: signed received passband sample, one per cycle.
- `carrier_I` in WIDTH: signed cos reference, aligned with `rx`.
- `carrier_Q` in WIDTH: signed sin reference, aligned with `rx`.
- `demod_en` in 1: run enable.
- `is_bpsk` in 1: mode select. 1 = BPSK, 0 = QPSK.
- `SYM_PHASE` in 4: symbol-boundary phase.
- `FRAME_LEN` in 16: symbols per frame. 0 = `tlast` never asserted.
- `m_tdata` out BYTES*8: decided bits in `[1:0]` as {I,Q}; upper bits 0.
- `m_tvalid` out 1: AXIS valid.
- `m_tready` in 1: AXIS ready.
- `m_tlast` out 1: last symbol of frame.
- `m_tuser` out 1: `is_bpsk` of this symbol.
- `sym_strobe` out 1: one-cycle pulse at each dump.
- `overflow` out 1: sticky flag, symbol dropped.

## Operation
- **Phase counter.** 4-bit `cnt` increments every cycle while `demod_en = 1`. It holds at 0 while `demod_en = 0`.
- **Symbol window.** A window is the 16 consecutive samples starting with the sample presented when `cnt == SYM_PHASE`.
- **Mixing and accumulation.**
  - Per lane, product = `rx` × carrier (2·WIDTH bits).
  - Accumulator width is 2·WIDTH+4 signed bits; overflow is impossible.
  - The first product of a window loads the accumulator; the others add.
- **Signal convention.** rx = a_I·cos + a_Q·sin, with a = ±A.
- **QPSK decision.**
  - bit_I = (acc_I ≥ 0); bit_Q = (acc_Q ≥ 0).
  - A zero accumulator decides 1.
- **BPSK decision.**
  - b = (acc_I + acc_Q ≥ 0), computed at 2·WIDTH+5 bits.
  - `m_tdata[1:0]` = {b,b}.
- **Mode sampling.** `is_bpsk` is sampled at window start and travels with the symbol to `m_tuser`.
- **Framing.**
  - A symbol counter increments on each emitted symbol.
  - `m_tlast` = 1 when count == FRAME_LEN−1, after which the counter wraps to 0.
  - If FRAME_LEN = 0, `m_tlast` stays 0.
- **Output register (single entry).**
  - Loaded at dump if empty, or if `m_tready` = 1 in that same cycle.
  - Otherwise the new symbol is dropped and `overflow` is set. The held symbol stays unchanged.
  - A dropped symbol does not advance the frame counter.
- **Handshake.** AXIS rules apply. `m_tdata`, `m_tlast` and `m_tuser` are stable while `m_tvalid && !m_tready`. `m_tvalid` never depends combinationally on `m_tready`.
- **Disable.** `demod_en` falling edge:
  - In-flight pipeline and partial window are discarded; no partial symbol is ever emitted.
  - The frame counter is cleared.
  - An already-valid output is kept until accepted.
- **Quasi-static inputs.** `SYM_PHASE` and `FRAME_LEN` may change only while `demod_en = 0`. Otherwise behaviour is undefined but must not lock up.
- **Overflow.** `overflow` clears only on reset.

## Timing
- **Reset.** All outputs are 0 the cycle after reset is sampled: `m_tdata`, `m_tvalid`, `m_tlast`, `m_tuser`, `sym_strobe`, `overflow`. `cnt`, accumulators and the frame counter are also cleared. Reset mid-window discards everything.
- **Pipeline.**
  - Stage 1 registers the product.
  - Stage 2 accumulates.
  - Stage 3 makes the decision and loads the output register.
- **Latency.** `m_tvalid` rises 3 cycles after the cycle in which the window's 16th sample is presented. `sym_strobe` pulses in that same cycle.
- **Throughput.** One symbol per 16 cycles. With `m_tready` held 1, `m_tvalid` is a 1-cycle pulse every 16 cycles.
- **First window after enable.** `demod_en` rises with `cnt` = 0. The first window starts at the cycle where cnt == SYM_PHASE.

## Structure
- **Package `psk_pkg`.**
  - `SPS` = 16.
  - Accumulator width function (2·W+4).
  - Bit-field positions: I = bit 1, Q = bit 0.
  - BPSK/QPSK encoding shared with the modulator.
- **Sub-module `psk_corr_acc`.** One mixer plus integrate-and-dump lane, with a load/add control and a registered result. It is instantiated twice (I, Q).
- **Top level.** Holds the counter, decision logic, frame counter and AXIS output register.

## Test plan
- **Reset.** Drive reset with `demod_en` = 1 and random `rx` → every output 0 the next cycle; no `m_tvalid` until a full window completes after release.
- **QPSK decisions.**
  - Stimulus: carrier = 16-point cos/sin table, amplitude 2047, `SYM_PHASE` = 0, `m_tready` = 1.
  - `rx` = ±cos±sin for symbol pairs (+,+), (−,+), (+,−), (−,−).
  - Required: `m_tdata[1:0]` = 11, 01, 10, 00 with `m_tuser` = 0.
  - Each `m_tvalid` arrives exactly 3 cycles after the window's last sample.
- **BPSK decisions.** `is_bpsk` = 1, `rx` = −(cos+sin), then +(cos+sin) → `m_tdata[1:0]` = 00 then 11, `m_tuser` = 1.
- **Backpressure and overflow.** `m_tready` = 0 across 2 dumps → first symbol held stable, second dropped, `overflow` = 1 and sticky. Raise `m_tready` → exactly one transfer.
- **Framing.** `FRAME_LEN` = 4, 10 symbols → `m_tlast` on symbols 4 and 8 only. `FRAME_LEN` = 0 → no `tlast`.
- **Phase, tie and abort.**
  - `SYM_PHASE` = 5, `rx` = 0 → first window begins at cnt = 5, decision 11.
  - Drop `demod_en` mid-window → no symbol is emitted from the partial window.
